// File: rtl/vga_pkg.sv
// Shared VGA definitions: 12-bit colour type, default 640x480@60 timing,
// colour palette and the box motion direction type.
package vga_pkg;

   typedef logic [11:0] rgb12_t;

   // Motion direction of one box axis
   typedef enum logic {
      DIR_INC = 1'b0,
      DIR_DEC = 1'b1
   } dir_t;

   // Default 640x480@60 timing (25 MHz pixel clock)
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // Palette
   localparam rgb12_t PAL_BLACK   = 12'h000;
   localparam rgb12_t PAL_RED     = 12'hF00;
   localparam rgb12_t PAL_GREEN   = 12'h0F0;
   localparam rgb12_t PAL_BLUE    = 12'h00F;
   localparam rgb12_t PAL_YELLOW  = 12'hFF0;
   localparam rgb12_t PAL_MAGENTA = 12'hF0F;

   // Box colour for a bounce colour index; index 0 is the configured foreground
   function automatic rgb12_t pal_sel(input logic [1:0] idx, input rgb12_t fg);
      rgb12_t c;
      case (idx)
         2'd0:    c = fg;
         2'd1:    c = PAL_GREEN;
         2'd2:    c = PAL_YELLOW;
         default: c = PAL_MAGENTA;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing: horizontal/vertical counters, active-low syncs,
// active-area flag and a strobe on the last pixel of the frame.
// All outputs are combinational decodes of the counter registers.
module vga_timing
   import vga_pkg::*;
#(
   parameter  int H_ACTIVE = DEF_H_ACTIVE,
   parameter  int H_FP     = DEF_H_FP,
   parameter  int H_SYNC   = DEF_H_SYNC,
   parameter  int H_BP     = DEF_H_BP,
   parameter  int V_ACTIVE = DEF_V_ACTIVE,
   parameter  int V_FP     = DEF_V_FP,
   parameter  int V_SYNC   = DEF_V_SYNC,
   parameter  int V_BP     = DEF_V_BP,
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW       = $clog2(H_TOTAL),
   localparam int VW       = $clog2(V_TOTAL)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   output logic [HW-1:0] o_hcnt,
   output logic [VW-1:0] o_vcnt,
   output logic          o_hsync_n,
   output logic          o_vsync_n,
   output logic          o_active,
   output logic          o_frame_end
);

   logic [HW-1:0] r_hcnt;
   logic [VW-1:0] r_vcnt;
   logic          w_h_last;
   logic          w_v_last;

   assign w_h_last = (r_hcnt == HW'(H_TOTAL - 1));
   assign w_v_last = (r_vcnt == VW'(V_TOTAL - 1));

   // Raster counters: hcnt free-runs, vcnt advances on each hcnt wrap
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
      end else if (w_h_last) begin
         r_hcnt <= '0;
         r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
      end else begin
         r_hcnt <= r_hcnt + 1'b1;
      end
   end

   assign o_hcnt      = r_hcnt;
   assign o_vcnt      = r_vcnt;
   assign o_hsync_n   = !((r_hcnt >= HW'(H_ACTIVE + H_FP)) &&
                          (r_hcnt <  HW'(H_ACTIVE + H_FP + H_SYNC)));
   assign o_vsync_n   = !((r_vcnt >= VW'(V_ACTIVE + V_FP)) &&
                          (r_vcnt <  VW'(V_ACTIVE + V_FP + V_SYNC)));
   assign o_active    = (r_hcnt < HW'(H_ACTIVE)) && (r_vcnt < VW'(V_ACTIVE));
   assign o_frame_end = w_h_last && w_v_last;

endmodule

// File: rtl/bouncing_box_gen.sv
// 640x480@60 VGA generator drawing one rectangle that bounces in X and Y.
// Position moves once per frame, on the last pixel, so it never changes
// inside the active area. All outputs are registered one cycle after the
// raster counters and stay mutually aligned.
// Optional macro BOUNCE_COLOR_EN: box colour steps through a 4-entry
// palette on every frame in which either axis bounces.
module bouncing_box_gen
   import vga_pkg::*;
#(
   parameter int     H_ACTIVE = DEF_H_ACTIVE,
   parameter int     H_FP     = DEF_H_FP,
   parameter int     H_SYNC   = DEF_H_SYNC,
   parameter int     H_BP     = DEF_H_BP,
   parameter int     V_ACTIVE = DEF_V_ACTIVE,
   parameter int     V_FP     = DEF_V_FP,
   parameter int     V_SYNC   = DEF_V_SYNC,
   parameter int     V_BP     = DEF_V_BP,
   parameter int     BOX_W    = 80,
   parameter int     BOX_H    = 80,
   parameter int     SPD_W    = 4,
   parameter rgb12_t FG_RGB   = PAL_BLUE,
   parameter rgb12_t BG_RGB   = PAL_RED
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [SPD_W-1:0] speed_x,
   input  logic [SPD_W-1:0] speed_y,
   output logic [3:0]       vgaRed,
   output logic [3:0]       vgaGreen,
   output logic [3:0]       vgaBlue,
   output logic             Hsync,
   output logic             Vsync,
   output logic             frame_tick
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int XMAX    = H_ACTIVE - BOX_W;
   localparam int YMAX    = V_ACTIVE - BOX_H;

   logic [HW-1:0] w_hcnt;
   logic [VW-1:0] w_vcnt;
   logic          w_hsync_n, w_vsync_n, w_active, w_frame_end;

   vga_timing #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .i_clk       (clk),
      .i_rst       (rst),
      .o_hcnt      (w_hcnt),
      .o_vcnt      (w_vcnt),
      .o_hsync_n   (w_hsync_n),
      .o_vsync_n   (w_vsync_n),
      .o_active    (w_active),
      .o_frame_end (w_frame_end)
   );

   logic [HW-1:0] r_box_x;
   logic [VW-1:0] r_box_y;
   dir_t          r_dir_x, r_dir_y;

   // One bit wider than the position so pos+s can never wrap
   logic [HW:0]   w_sx, w_x_sum;
   logic [VW:0]   w_sy, w_y_sum;
   logic [HW-1:0] w_x_nxt;
   logic [VW-1:0] w_y_nxt;
   dir_t          w_dx_nxt, w_dy_nxt;
   logic          w_flip_x, w_flip_y;

   assign w_sx    = (HW+1)'(speed_x);
   assign w_sy    = (VW+1)'(speed_y);
   assign w_x_sum = {1'b0, r_box_x} + w_sx;
   assign w_y_sum = {1'b0, r_box_y} + w_sy;

   // X axis next position: clamp at the wall and reverse; zero speed holds
   always_comb begin
      w_x_nxt  = r_box_x;
      w_dx_nxt = r_dir_x;
      w_flip_x = 1'b0;
      if (speed_x != '0) begin
         if (r_dir_x == DIR_INC) begin
            if (w_x_sum >= (HW+1)'(XMAX)) begin
               w_x_nxt  = HW'(XMAX);
               w_dx_nxt = DIR_DEC;
               w_flip_x = 1'b1;
            end else begin
               w_x_nxt = w_x_sum[HW-1:0];
            end
         end else begin
            if ({1'b0, r_box_x} <= w_sx) begin
               w_x_nxt  = '0;
               w_dx_nxt = DIR_INC;
               w_flip_x = 1'b1;
            end else begin
               w_x_nxt = r_box_x - w_sx[HW-1:0];
            end
         end
      end
   end

   // Y axis next position: same rule as X, independent of it
   always_comb begin
      w_y_nxt  = r_box_y;
      w_dy_nxt = r_dir_y;
      w_flip_y = 1'b0;
      if (speed_y != '0) begin
         if (r_dir_y == DIR_INC) begin
            if (w_y_sum >= (VW+1)'(YMAX)) begin
               w_y_nxt  = VW'(YMAX);
               w_dy_nxt = DIR_DEC;
               w_flip_y = 1'b1;
            end else begin
               w_y_nxt = w_y_sum[VW-1:0];
            end
         end else begin
            if ({1'b0, r_box_y} <= w_sy) begin
               w_y_nxt  = '0;
               w_dy_nxt = DIR_INC;
               w_flip_y = 1'b1;
            end else begin
               w_y_nxt = r_box_y - w_sy[VW-1:0];
            end
         end
      end
   end

   // Box position/direction, committed only on the last pixel of a running frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_box_x <= '0;
         r_box_y <= '0;
         r_dir_x <= DIR_INC;
         r_dir_y <= DIR_INC;
      end else if (w_frame_end && run) begin
         r_box_x <= w_x_nxt;
         r_box_y <= w_y_nxt;
         r_dir_x <= w_dx_nxt;
         r_dir_y <= w_dy_nxt;
      end
   end

   rgb12_t w_box_rgb;

`ifdef BOUNCE_COLOR_EN
   logic [1:0] r_cidx;

   // Colour index advances once for any frame that bounces on either axis
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cidx <= 2'd0;
      end else if (w_frame_end && run && (w_flip_x || w_flip_y)) begin
         r_cidx <= r_cidx + 2'd1;
      end
   end

   assign w_box_rgb = pal_sel(r_cidx, FG_RGB);
`else
   assign w_box_rgb = FG_RGB;
`endif

   logic   w_hit;
   rgb12_t w_pix_rgb;

   assign w_hit = (w_hcnt >= r_box_x) &&
                  ({1'b0, w_hcnt} < ({1'b0, r_box_x} + (HW+1)'(BOX_W))) &&
                  (w_vcnt >= r_box_y) &&
                  ({1'b0, w_vcnt} < ({1'b0, r_box_y} + (VW+1)'(BOX_H)));

   // Pixel mux: box over background inside the active area, black outside
   always_comb begin
      w_pix_rgb = PAL_BLACK;
      if (w_active) begin
         w_pix_rgb = w_hit ? w_box_rgb : BG_RGB;
      end
   end

   rgb12_t r_rgb;
   logic   r_hsync, r_vsync, r_tick;

   // Output stage: one register for every output keeps them aligned
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rgb   <= PAL_BLACK;
         r_hsync <= 1'b1;
         r_vsync <= 1'b1;
         r_tick  <= 1'b0;
      end else begin
         r_rgb   <= w_pix_rgb;
         r_hsync <= w_hsync_n;
         r_vsync <= w_vsync_n;
         r_tick  <= w_frame_end;
      end
   end

   assign vgaRed     = r_rgb[11:8];
   assign vgaGreen   = r_rgb[7:4];
   assign vgaBlue    = r_rgb[3:0];
   assign Hsync      = r_hsync;
   assign Vsync      = r_vsync;
   assign frame_tick = r_tick;

endmodule

// File: tb/tb_bouncing_box_gen.sv
// Self-checking bench for bouncing_box_gen, built with a reduced raster
// (24x16 total, 16x12 active, 4x3 box) so many frames fit in a short run.
// A frame-level model of box motion plus raster decode predicts every
// output on every cycle; directed literals pin the model itself.
module tb_bouncing_box_gen;

   localparam int HA = 16, HF = 2, HS = 3, HB = 3;
   localparam int VA = 12, VF = 1, VS = 2, VB = 1;
   localparam int BW = 4, BH = 3, SW = 4;
   localparam int HT = HA + HF + HS + HB;   // 24
   localparam int VT = VA + VF + VS + VB;   // 16
   localparam int FT = HT * VT;             // 384
   localparam int XMAX = HA - BW;           // 12
   localparam int YMAX = VA - BH;           // 9
   localparam logic [11:0] FG = 12'h00F;
   localparam logic [11:0] BG = 12'hF00;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          run = 1'b0;
   logic [SW-1:0] speed_x = '0;
   logic [SW-1:0] speed_y = '0;
   logic [3:0]    vgaRed, vgaGreen, vgaBlue;
   logic          Hsync, Vsync, frame_tick;

   bouncing_box_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .BOX_W(BW), .BOX_H(BH), .SPD_W(SW),
      .FG_RGB(FG), .BG_RGB(BG)
   ) dut (
      .clk(clk), .rst(rst), .run(run),
      .speed_x(speed_x), .speed_y(speed_y),
      .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
      .Hsync(Hsync), .Vsync(Vsync), .frame_tick(frame_tick)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int k = 0;          // clock edges since reset released
   int cur_h = 0, cur_v = 0;
   int m_x = 0, m_y = 0, m_dx = 1, m_dy = 1, m_ci = 0;
   int upd_cnt = 0;    // frame ends seen (with or without motion)

   function automatic void step_axis(inout int pos, inout int dir, input int s,
                                     input int mx, inout int flipped);
      if (s == 0) return;
      if (dir > 0) begin
         if (pos + s >= mx) begin pos = mx; dir = -1; flipped = 1; end
         else pos = pos + s;
      end else begin
         if (pos <= s) begin pos = 0; dir = 1; flipped = 1; end
         else pos = pos - s;
      end
   endfunction

   function automatic logic [11:0] box_colour(input int ci);
`ifdef BOUNCE_COLOR_EN
      logic [11:0] pal [4];
      pal[0] = FG; pal[1] = 12'h0F0; pal[2] = 12'hFF0; pal[3] = 12'hF0F;
      return pal[ci];
`else
      return (ci >= 0) ? FG : FG;
`endif
   endfunction

   // Compare process: every cycle, just after the clock edge
   always @(posedge clk) begin
      int p, h, v, fx;
      logic [11:0] e_rgb;
      #1;
      if (rst) begin
         k = 0; m_x = 0; m_y = 0; m_dx = 1; m_dy = 1; m_ci = 0;
         chk("rst_rgb", {vgaRed, vgaGreen, vgaBlue}, 12'h000);
         chk("rst_hsync", Hsync, 1'b1);
         chk("rst_vsync", Vsync, 1'b1);
         chk("rst_tick", frame_tick, 1'b0);
      end else begin
         k++;
         p = (k - 1) % FT;
         h = p % HT;
         v = p / HT;
         cur_h = h;
         cur_v = v;
         if (h < HA && v < VA) begin
            if (h >= m_x && h < m_x + BW && v >= m_y && v < m_y + BH) e_rgb = box_colour(m_ci);
            else e_rgb = BG;
         end else begin
            e_rgb = 12'h000;
         end
         chk("rgb", {vgaRed, vgaGreen, vgaBlue}, e_rgb);
         chk("hsync", Hsync, !(h >= HA + HF && h < HA + HF + HS));
         chk("vsync", Vsync, !(v >= VA + VF && v < VA + VF + VS));
         chk("frame_tick", frame_tick, (p == FT - 1));
         if (p == FT - 1) begin
            upd_cnt++;
            if (run) begin
               fx = 0;
               step_axis(m_x, m_dx, int'(speed_x), XMAX, fx);
               step_axis(m_y, m_dy, int'(speed_y), YMAX, fx);
               if (fx != 0) m_ci = (m_ci + 1) % 4;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic wait_updates(input int n);
      int target, budget;
      target = upd_cnt + n;
      budget = (n + 1) * FT + 10;
      while (upd_cnt < target && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (upd_cnt < target) chk("wait_updates_timeout", upd_cnt, target);
   endtask

   task automatic step_sample();
      @(posedge clk); #2;
   endtask

   task automatic check_pixel(input string name, input int h, input int v, input logic [11:0] exp);
      int budget;
      budget = FT + 5;
      do begin
         step_sample();
         budget--;
      end while (!(cur_h == h && cur_v == v && !rst) && budget > 0);
      chk({name, "_reached"}, (budget > 0), 1);
      chk(name, {vgaRed, vgaGreen, vgaBlue}, exp);
   endtask

   task automatic measure_sync();
      logic prev;
      int found, lo, per, n;
      // Hsync: falling edge position, low width, period
      found = 0; prev = Hsync;
      for (int i = 0; i < 3 * HT && found == 0; i++) begin
         step_sample();
         if (prev && !Hsync) found = 1; else prev = Hsync;
      end
      chk("hsync_fall_found", found, 1);
      chk("hsync_fall_hcnt", cur_h, 18);
      lo = 1; n = 0;
      while (!Hsync && n < 100) begin step_sample(); n++; if (!Hsync) lo++; end
      chk("hsync_low_width", lo, 3);
      per = lo; prev = Hsync; n = 0;
      while (n < 100) begin
         step_sample(); n++; per++;
         if (prev && !Hsync) break;
         prev = Hsync;
      end
      chk("hsync_period", per, 24);
      // Vsync: falling edge line and low width in cycles
      found = 0; prev = Vsync;
      for (int i = 0; i < 2 * FT && found == 0; i++) begin
         step_sample();
         if (prev && !Vsync) found = 1; else prev = Vsync;
      end
      chk("vsync_fall_found", found, 1);
      chk("vsync_fall_line", cur_v, 13);
      chk("vsync_fall_hcnt", cur_h, 0);
      lo = 1; n = 0;
      while (!Vsync && n < 200) begin step_sample(); n++; if (!Vsync) lo++; end
      chk("vsync_low_cycles", lo, 48);
   endtask

   task automatic count_ticks();
      int cnt, first, second;
      cnt = 0; first = -1; second = -1;
      for (int i = 0; i < 2 * FT; i++) begin
         step_sample();
         if (frame_tick) begin
            cnt++;
            if (first < 0) first = i; else if (second < 0) second = i;
         end
      end
      chk("tick_count_2frames", cnt, 2);
      chk("tick_period", second - first, 384);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Free run, box parked
      measure_sync();
      count_ticks();
      chk("park_x", m_x, 0);
      chk("park_y", m_y, 0);

      // X only, speed 5: 5, 10, 12 (bounce), 7, 2, 0 (bounce)
      do_reset(); speed_x = 4'd5; speed_y = 4'd0; run = 1'b1;
      wait_updates(1); chk("sx5_u1", m_x, 5);
      wait_updates(1); chk("sx5_u2", m_x, 10);
      wait_updates(1); chk("sx5_u3", m_x, 12); chk("sx5_u3_dir", m_dx, -1);
      wait_updates(1); chk("sx5_u4", m_x, 7);
      wait_updates(2); chk("sx5_u6", m_x, 0);  chk("sx5_u6_dir", m_dx, 1);
      chk("sx5_y", m_y, 0);

      // Speed 7 near the right wall: 7, 12 clamped, 5
      do_reset(); speed_x = 4'd7; speed_y = 4'd0; run = 1'b1;
      wait_updates(1); chk("sx7_u1", m_x, 7);
      wait_updates(1); chk("sx7_clamp", m_x, 12); chk("sx7_dir", m_dx, -1);
      wait_updates(1); chk("sx7_back", m_x, 5);

      // Corner hit: 4/3 reaches (12,9) on the same frame
      do_reset(); speed_x = 4'd4; speed_y = 4'd3; run = 1'b1;
      wait_updates(2); chk("corner_pre_x", m_x, 8); chk("corner_pre_y", m_y, 6);
      wait_updates(1);
      chk("corner_x", m_x, 12); chk("corner_y", m_y, 9);
      chk("corner_dx", m_dx, -1); chk("corner_dy", m_dy, -1);
`ifdef BOUNCE_COLOR_EN
      chk("corner_cidx", m_ci, 1);
`endif
      wait_updates(1); chk("corner_after_x", m_x, 8); chk("corner_after_y", m_y, 6);

      // Pixel edges with the box parked at (4,3)
      do_reset(); speed_x = 4'd4; speed_y = 4'd3; run = 1'b1;
      wait_updates(1); run = 1'b0;
      chk("pix_box_x", m_x, 4); chk("pix_box_y", m_y, 3);
      check_pixel("pix_left_out", 3, 3, 12'hF00);
      check_pixel("pix_left_in", 4, 3, 12'h00F);
      check_pixel("pix_right_in", 7, 5, 12'h00F);
      check_pixel("pix_below", 4, 6, 12'hF00);
      check_pixel("pix_right_out", 8, 3, 12'hF00);
      check_pixel("pix_hblank", 16, 3, 12'h000);
      check_pixel("pix_vblank", 4, 12, 12'h000);

      // Mid-line asynchronous reset, then frozen position, then resume
      run = 1'b1;
      wait_updates(1);
      repeat (30) @(negedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_rgb", {vgaRed, vgaGreen, vgaBlue}, 12'h000);
      chk("async_hsync", Hsync, 1'b1);
      chk("async_vsync", Vsync, 1'b1);
      chk("async_tick", frame_tick, 1'b0);
      run = 1'b0;
      @(negedge clk); @(negedge clk); rst = 1'b0;
      wait_updates(3);
      chk("frozen_x", m_x, 0); chk("frozen_y", m_y, 0);
      run = 1'b1;
      wait_updates(1);
      chk("resume_x", m_x, 4); chk("resume_y", m_y, 3);
      repeat (FT / 2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
